// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// address-split width helpers and the NOP filler instruction.
package icache_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic int off_w(input int words_per_line);
        return $clog2(words_per_line) + 2;
    endfunction

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int num_lines, input int words_per_line);
        return addr_w - idx_w(num_lines) - off_w(words_per_line);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag and data storage for the instruction cache: one combinational read port
// and one synchronous write port. Validity is tracked by the controller.
module icache_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 25,
    parameter int IDX_W          = idx_w(NUM_LINES),
    parameter int WRD_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [WRD_W-1:0] i_rd_word,
    output logic [31:0]      o_rd_data,
    output logic [TAG_W-1:0] o_rd_tag,
    input  logic             i_we,
    input  logic             i_tag_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [WRD_W-1:0] i_wr_word,
    input  logic [31:0]      i_wr_data,
    input  logic [TAG_W-1:0] i_wr_tag
);

    logic [31:0]      r_data [NUM_LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0] r_tag  [NUM_LINES];

    // NOTE: storage carries no reset; stale contents are harmless because a line
    // can only hit once its valid bit is set after a complete refill.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_data[i_wr_idx][i_wr_word] <= i_wr_data;
            if (i_tag_we) begin
                r_tag[i_wr_idx] <= i_wr_tag;
            end
        end
    end

    assign o_rd_data = r_data[i_rd_idx][i_rd_word];
    assign o_rd_tag  = r_tag[i_rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with whole-line refill.
// Define ICACHE_STATS_EN to add hit_cnt/miss_cnt statistics outputs.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int OFF_W = off_w(WORDS_PER_LINE);
    localparam int IDX_W = idx_w(NUM_LINES);
    localparam int TAG_W = tag_w(ADDR_W, NUM_LINES, WORDS_PER_LINE);
    localparam int WRD_W = OFF_W - 2;
    localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(WORDS_PER_LINE - 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_base_tag;
    logic [IDX_W-1:0]     r_base_idx;
    logic [WRD_W-1:0]     r_word_cnt;
    logic                 r_abort;

    logic [TAG_W-1:0]     w_tag;
    logic [IDX_W-1:0]     w_idx;
    logic [WRD_W-1:0]     w_word;
    logic [31:0]          w_rd_data;
    logic [TAG_W-1:0]     w_rd_tag;
    logic                 w_lookup;
    logic                 w_tag_match;
    logic                 w_hit;
    logic                 w_start;
    logic                 w_last_ack;
    logic                 w_fill_we;
    logic                 w_unused_pc_lsb;

    assign w_tag           = pc[ADDR_W-1 -: TAG_W];
    assign w_idx           = pc[OFF_W +: IDX_W];
    assign w_word          = pc[2 +: WRD_W];
    assign w_unused_pc_lsb = ^pc[1:0];

    assign w_lookup    = (r_state == ST_IDLE) && fetch_req && !flush;
    assign w_tag_match = r_valid[w_idx] && (w_rd_tag == w_tag);
    assign w_hit       = w_lookup && w_tag_match;
    assign w_start     = w_lookup && !w_tag_match;
    assign w_fill_we   = (r_state == ST_REFILL) && mem_ack;
    assign w_last_ack  = w_fill_we && (r_word_cnt == LAST_WORD);

    icache_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_array (
        .clk       (clk),
        .i_rd_idx  (w_idx),
        .i_rd_word (w_word),
        .o_rd_data (w_rd_data),
        .o_rd_tag  (w_rd_tag),
        .i_we      (w_fill_we),
        .i_tag_we  (w_last_ack),
        .i_wr_idx  (r_base_idx),
        .i_wr_word (r_word_cnt),
        .i_wr_data (mem_rdata),
        .i_wr_tag  (r_base_tag)
    );

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        instr       = NOP_INSTR;
        instr_valid = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    instr       = w_rd_data;
                    instr_valid = 1'b1;
                end
                if (w_start) begin
                    w_state_nxt = ST_REFILL;
                end
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_base_tag, r_base_idx, r_word_cnt, 2'b00};
                if (w_last_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        stall = (fetch_req && !instr_valid) || (r_state != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, and reset is
    // sampled synchronously inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_valid    <= '0;
            r_base_tag <= '0;
            r_base_idx <= '0;
            r_word_cnt <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_valid <= '0;
            end
            if (w_start) begin
                r_base_tag     <= w_tag;
                r_base_idx     <= w_idx;
                r_word_cnt     <= '0;
                r_abort        <= 1'b0;
                r_valid[w_idx] <= 1'b0;
            end
            if (w_fill_we) begin
                r_word_cnt <= r_word_cnt + WRD_W'(1);
            end
            // A flush anywhere in the refill, including on the final ack, keeps the line invalid.
            if (w_last_ack) begin
                r_abort <= 1'b0;
                if (!r_abort && !flush) begin
                    r_valid[r_base_idx] <= 1'b1;
                end
            end else if ((r_state == ST_REFILL) && flush) begin
                r_abort <= 1'b1;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (w_hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (w_start) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus randomized traffic
// against a line-address-set model of the cache and a hashed backing memory.
module tb_icache_ctrl;
    import icache_pkg::*;

    localparam int NUM_LINES = 8;
    localparam int WPL       = 4;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Set of line addresses (byte address / 16) currently expected to hit.
    bit cached [int unsigned];

    icache_ctrl #(
        .ADDR_W         (32),
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0006_0613;
        if (a == 32'h8) return 32'h00C6_8733;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic evict(input logic [31:0] a);
        int unsigned keys[$];
        int unsigned idx;
        idx = (a >> 4) % NUM_LINES;
        foreach (cached[k]) if ((k % NUM_LINES) == idx) keys.push_back(k);
        foreach (keys[i]) cached.delete(keys[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; fetch_req = 1'b0; flush = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cached.delete();
    endtask

    // One fetch at address a; on a miss, serves the refill with `delay` idle
    // cycles before each ack, optionally flushing on the ack of word flush_word.
    task automatic access(input logic [31:0] a, input int delay, input int flush_word, input bit toggle);
        logic [31:0] base;
        bit          aborted;
        base = {a[31:4], 4'b0000};
        @(negedge clk);
        fetch_req = 1'b1; pc = a; flush = 1'b0; mem_ack = 1'b0; mem_rdata = $urandom;
        #1;
        if (cached.exists(a >> 4)) begin
            checks++;
            if ({instr_valid, stall, mem_req, instr} !== {1'b1, 1'b0, 1'b0, mem_word(a)}) begin
                errors++;
                $display("FAIL hit pc=%h: got valid=%0d stall=%0d req=%0d instr=%h, expected 1/0/0 instr=%h",
                         a, instr_valid, stall, mem_req, instr, mem_word(a));
            end
        end else begin
            checks++;
            if ({instr_valid, stall, mem_req, instr} !== {1'b0, 1'b1, 1'b0, NOP_INSTR}) begin
                errors++;
                $display("FAIL miss pc=%h: got valid=%0d stall=%0d req=%0d instr=%h, expected 0/1/0 instr=%h",
                         a, instr_valid, stall, mem_req, instr, NOP_INSTR);
            end
            evict(a);
            aborted = 1'b0;
            for (int w = 0; w < WPL; w++) begin
                for (int d = 0; d <= delay; d++) begin
                    @(negedge clk);
                    mem_ack   = (d == delay);
                    mem_rdata = mem_ack ? mem_word(base + 32'(4 * w)) : $urandom;
                    flush     = mem_ack && (w == flush_word);
                    if (toggle) begin
                        fetch_req = 1'($urandom);
                        pc        = $urandom & 32'h0000_0FFC;
                    end else begin
                        fetch_req = 1'b0;
                    end
                    #1;
                    checks++;
                    if ({mem_req, stall, instr_valid, mem_addr} !== {1'b1, 1'b1, 1'b0, base + 32'(4 * w)}) begin
                        errors++;
                        $display("FAIL refill word %0d: got req=%0d stall=%0d valid=%0d addr=%h, expected 1/1/0 addr=%h",
                                 w, mem_req, stall, instr_valid, mem_addr, base + 32'(4 * w));
                    end
                    if (flush) begin
                        cached.delete();
                        aborted = 1'b1;
                    end
                end
            end
            @(negedge clk);
            mem_ack = 1'b0; flush = 1'b0; fetch_req = 1'b0;
            #1;
            checks++;
            if ({mem_req, stall} !== 2'b00) begin
                errors++;
                $display("FAIL refill_end pc=%h: got req=%0d stall=%0d, expected 0/0", a, mem_req, stall);
            end
            if (!aborted) cached[a >> 4] = 1'b1;
        end
    endtask

    task automatic flush_idle(input logic [31:0] a);
        @(negedge clk);
        fetch_req = 1'b1; pc = a; flush = 1'b1; mem_ack = 1'b0;
        #1;
        checks++;
        if ({instr_valid, stall, instr} !== {1'b0, 1'b1, NOP_INSTR}) begin
            errors++;
            $display("FAIL flush_idle pc=%h: got valid=%0d stall=%0d instr=%h, expected 0/1 instr=%h",
                     a, instr_valid, stall, instr, NOP_INSTR);
        end
        cached.delete();
        @(negedge clk);
        flush = 1'b0; fetch_req = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_refill: got req=%0d, expected 0", mem_req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_req = 1'b0; pc = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({instr, instr_valid, stall, mem_req, mem_addr} !== {NOP_INSTR, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset: got instr=%h valid=%0d stall=%0d req=%0d addr=%h, expected %h/0/0/0/0",
                     instr, instr_valid, stall, mem_req, mem_addr, NOP_INSTR);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cached.delete();
    endtask

    task automatic test_cold_fill();
        access(32'h00, 2, -1, 1'b0);
        access(32'h00, 2, -1, 1'b0);
    endtask

    task automatic test_hit_and_next_line();
        access(32'h08, 2, -1, 1'b0);
        access(32'h10, 2, -1, 1'b0);
        access(32'h1C, 2, -1, 1'b0);
    endtask

    task automatic test_conflict();
        access(32'h00, 2, -1, 1'b0);
        access(32'h80, 2, -1, 1'b0);
        access(32'h00, 2, -1, 1'b0);
        access(32'h84, 2, -1, 1'b0);
    endtask

    task automatic test_flush();
        access(32'h20, 2, 1, 1'b0);
        access(32'h20, 2, -1, 1'b0);
        access(32'h40, 1, WPL - 1, 1'b0);
        access(32'h44, 1, -1, 1'b0);
        access(32'h48, 1, -1, 1'b0);
        flush_idle(32'h48);
        access(32'h48, 0, -1, 1'b0);
    endtask

    task automatic test_stall_hold();
        access(32'h100, 10, -1, 1'b1);
        access(32'h10C, 2, -1, 1'b0);
    endtask

    task automatic test_reset_mid_refill();
        @(negedge clk);
        fetch_req = 1'b1; pc = 32'h200; flush = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_refill_req: got req=%0d, expected 1", mem_req);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_addr, stall} !== {1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_refill: got req=%0d addr=%h stall=%0d, expected 0/0/0", mem_req, mem_addr, stall);
        end
        cached.delete();
        access(32'h200, 1, -1, 1'b0);
        access(32'h204, 1, -1, 1'b0);
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        do_reset();
        #1;
        checks++;
        if ({hit_cnt, miss_cnt} !== 64'h0) begin
            errors++;
            $display("FAIL stats_reset: got hit=%0d miss=%0d, expected 0/0", hit_cnt, miss_cnt);
        end
        access(32'h300, 2, -1, 1'b0);
        access(32'h300, 2, -1, 1'b0);
        access(32'h304, 2, -1, 1'b0);
        access(32'h308, 2, -1, 1'b0);
        flush_idle(32'h300);
        access(32'h300, 2, -1, 1'b0);
        checks++;
        if ({hit_cnt, miss_cnt} !== {32'd3, 32'd2}) begin
            errors++;
            $display("FAIL stats_count: got hit=%0d miss=%0d, expected 3/2", hit_cnt, miss_cnt);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] a;
        int          fw;
        for (int i = 0; i < 80; i++) begin
            a = $urandom & 32'h0000_03FC;
            if ($urandom_range(0, 9) == 0) begin
                flush_idle(a);
            end else begin
                fw = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, WPL - 1)) : -1;
                access(a, int'($urandom_range(0, 3)), fw, 1'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_fill();
        test_hit_and_next_line();
        test_conflict();
        test_flush();
        test_stall_hold();
        test_reset_mid_refill();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
